uart_rx_engine: RTL and testbench
=================================

Name: uart_rx_engine

Overview:
- Receive side of the team's UART; the counterpart of the transmit shift/bit-counter path.
- Synchronizes the serial input and detects a start bit by a mid-bit check.
- Samples each data, parity and stop bit at its bit centre, then presents the assembled byte with status flags to the register interface.
- Supports 9- to 11-bit frames: start, 7/8 data bits LSB first, optional parity, one stop bit.

Parameters:
- DIV_W, 19, width of the baud divisor input (clocks-per-bit count).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- rx  input  1  serial line; idle high; asynchronous to clk
- baud_count  input  DIV_W  clocks per bit time; legal range 4 .. 2^DIV_W-1
- eight  input  1  1 = 8 data bits, 0 = 7 data bits
- pen  input  1  parity enable
- ohel  input  1  parity sense: 1 = odd, 0 = even
- clr_rdy  input  1  one-cycle pulse from the host read; clears the status flags
- rx_data  output  8  received byte; bit 7 is forced to 0 in 7-bit mode
- rx_rdy  output  1  sticky flag: a frame has completed
- perr  output  1  sticky parity error
- ferr  output  1  sticky framing error (stop bit sampled 0)
- ovf  output  1  sticky overrun: a frame completed while rx_rdy was still set

Behaviour:
- Reset (reset=0, async): all outputs 0, FSM in IDLE, internal counters 0, synchronizer flops 1.
- Synchronizer: rx passes through 2 flops (rx_s). All decisions use rx_s. Latency from a pin edge to rx_s is 2 clk.
- Config capture: on start detect, latch baud_count, eight, pen and ohel. Changes to these inputs mid-frame have no effect on the current frame.
- Frame bits after start: nbits = 7 + eight + pen + 1 (range 8..10). The bit counter counts these and wraps to 0 at frame end.

FSM states and transitions:
- IDLE: a falling edge on rx_s (previous 1, current 0) enters START and clears the bit-time counter.
- START: count to baud_count>>1.
  - At the half-bit point, if rx_s=0, enter DATA and clear the counter.
  - If rx_s=1 (false start / glitch), return to IDLE; no flags change.
- DATA: count to baud_count-1, then sample rx_s into the shift register (shift right, MSB in) and increment the bit counter.
  - When bit counter = nbits-1 at the sample point, enter DONE.
- DONE (1 cycle):
  - Align the shift register to rx_data; for 7-bit mode bit 7=0.
  - Compute parity: perr <= pen & ((^data ^ parity_bit) != ohel).
  - ferr <= (stop bit == 0).
  - ovf <= rx_rdy & ~clr_rdy.
  - rx_rdy <= 1.
  - Next state is IDLE.
- Output latency: rx_rdy rises 1 clk after the stop-bit sample. rx_data, perr and ferr update in the same cycle as rx_rdy.
- Sticky flags:
  - rx_rdy, perr, ferr and ovf hold until clr_rdy.
  - clr_rdy clears all four.
  - If clr_rdy and DONE coincide, the new frame's values win: rx_rdy=1, perr/ferr from the new frame, ovf=0.
  - perr and ferr from an earlier frame are OR-accumulated only via overwrite: each DONE overwrites perr and ferr.
- Back-to-back frames: the FSM is in IDLE within 1 clk of DONE. A start edge arriving during DONE is detected on the next cycle (rx_s history kept in all states).
- Break (rx held 0): the frame completes with ferr=1 and data 0. No new start is detected until rx_s returns to 1 and falls again.
- Reset mid-frame: immediate abort to IDLE; partial data is discarded.

Decomposition:
- Package uart_rx_pkg:
  - state enum IDLE/START/DATA/DONE (2-bit encoding)
  - constants for minimum divisor (4) and maximum frame bits (10)
  - nbits function of eight/pen
- Sub-module rx_bit_timer:
  - loadable DIV_W counter with clear input
  - half-bit mode (terminal at div>>1) and full-bit mode (terminal at div-1)
  - outputs a one-cycle tick
  - This is the receive analogue of the transmit bit-time unit.
- Top level holds the synchronizer, FSM, 4-bit bit counter, shift register and flags.

Test Plan:
- 8N1 frame: baud_count=16, eight=1, pen=0; send 0xA5 -> rx_data=0xA5, rx_rdy=1 one clk after the stop sample, perr=ferr=ovf=0.
- 7E1 and 7O1: send 0x41 with correct even parity, then odd mode with a wrong parity bit -> rx_data=0x41 with perr=0, then perr=1.
- Glitch: 5-clk low pulse on rx with baud_count=16 -> FSM returns to IDLE; rx_rdy stays 0.
- Framing and overrun: send 0x3C with stop=0 -> ferr=1. Send a second frame without clr_rdy -> ovf=1, rx_data=new byte. Then pulse clr_rdy -> all flags 0.
- Coincident clr_rdy with DONE: clr_rdy asserted in the DONE cycle of frame 0x55 while rx_rdy=1 -> rx_rdy=1, ovf=0, rx_data=0x55.
- Reset mid-frame: drop reset after 4 data bits -> outputs 0 immediately. The next full frame 0xFF after release is received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared constants and helpers for the UART receive path.
// State codes are plain 2-bit constants so older tools can consume them.
package uart_rx_pkg;

   localparam logic [1:0] StIdle  = 2'd0;
   localparam logic [1:0] StStart = 2'd1;
   localparam logic [1:0] StData  = 2'd2;
   localparam logic [1:0] StDone  = 2'd3;

   localparam int unsigned MinDiv       = 4;
   localparam int unsigned MaxFrameBits = 10;

   // Bits following the start bit: data (7/8), optional parity, one stop.
   function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
      return 4'd8 + {3'd0, eight} + {3'd0, pen};
   endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// Bit-time counter for the receiver: ticks at the half-bit point or at the end
// of a full bit, then restarts from zero.
module rx_bit_timer #(
   parameter int unsigned DIV_W = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             half,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   localparam logic [DIV_W-1:0] One = 1;

   logic [DIV_W-1:0] cnt;
   logic [DIV_W-1:0] terminal;

   always_comb begin
      terminal = half ? (div >> 1) : (div - One);
   end

   assign tick = ~clear & (cnt == terminal);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + One;
      end
   end

endmodule

// File: rtl/uart_rx_engine.sv
// UART receiver: synchronizes rx, qualifies the start bit at mid-bit, samples
// each following bit at its centre and publishes the byte with sticky status.
module uart_rx_engine
   import uart_rx_pkg::*;
#(
   parameter int unsigned DIV_W = 19
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   input  logic [DIV_W-1:0] baud_count,
   input  logic             eight,
   input  logic             pen,
   input  logic             ohel,
   input  logic             clr_rdy,
   output logic [7:0]       rx_data,
   output logic             rx_rdy,
   output logic             perr,
   output logic             ferr,
   output logic             ovf
);

   localparam logic [3:0] MaxBits = 4'(MaxFrameBits);

   logic             rx_meta, rx_s, rx_prev;
   logic             start_edge, start_pend, idle_start;
   logic [1:0]       state, state_next;
   logic [DIV_W-1:0] div_cfg;
   logic             eight_cfg, pen_cfg, ohel_cfg;
   logic [3:0]       bit_cnt, nbits;
   logic             last_bit, tick;
   logic [9:0]       shreg, shifted;
   logic [7:0]       data_now;
   logic             par_bit, stop_bit;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = rx_prev & ~rx_s;
   // An edge seen while in DONE would be gone by the IDLE cycle; hold it over.
   assign idle_start = start_edge | start_pend;
   assign nbits      = frame_bits(eight_cfg, pen_cfg);
   assign last_bit   = (bit_cnt == nbits - 4'd1);

   rx_bit_timer #(
      .DIV_W (DIV_W)
   ) u_bit_timer (
      .clk   (clk),
      .reset (reset),
      .clear (state == StIdle),
      .half  (state == StStart),
      .div   (div_cfg),
      .tick  (tick)
   );

   always_comb begin
      state_next = state;
      unique case (state)
         StIdle:  if (idle_start) state_next = StStart;
         StStart: if (tick) state_next = rx_s ? StIdle : StData;
         StData:  if (tick && last_bit) state_next = StDone;
         StDone:  state_next = StIdle;
      endcase
   end

   // Received bits sit at the top of shreg; shift them down to bit 0.
   always_comb begin
      shifted  = shreg >> (MaxBits - nbits);
      data_now = {eight_cfg & shifted[7], shifted[6:0]};
      par_bit  = eight_cfg ? shifted[8] : shifted[7];
      stop_bit = shifted[nbits - 4'd1];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= StIdle;
         start_pend <= 1'b0;
         div_cfg    <= '0;
         eight_cfg  <= 1'b0;
         pen_cfg    <= 1'b0;
         ohel_cfg   <= 1'b0;
         bit_cnt    <= '0;
         shreg      <= '0;
      end else begin
         state      <= state_next;
         start_pend <= (state == StDone) & start_edge;
         if (state == StIdle && idle_start) begin
            div_cfg   <= baud_count;
            eight_cfg <= eight;
            pen_cfg   <= pen;
            ohel_cfg  <= ohel;
         end
         if (state == StData && tick) begin
            shreg   <= {rx_s, shreg[9:1]};
            bit_cnt <= last_bit ? 4'd0 : bit_cnt + 4'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_data <= '0;
         rx_rdy  <= 1'b0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         ovf     <= 1'b0;
      end else if (state == StDone) begin
         rx_data <= data_now;
         rx_rdy  <= 1'b1;
         perr    <= pen_cfg & ((^data_now ^ par_bit) != ohel_cfg);
         ferr    <= ~stop_bit;
         ovf     <= rx_rdy & ~clr_rdy;
      end else if (clr_rdy) begin
         rx_rdy <= 1'b0;
         perr   <= 1'b0;
         ferr   <= 1'b0;
         ovf    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_uart_rx_engine.sv
// Scoreboard bench for uart_rx_engine: each frame queues its expected result
// and completion cycle; a monitor compares the outputs when that cycle arrives.
module tb_uart_rx_engine;

   localparam int unsigned DIV_W = 19;

   logic             clk = 1'b0;
   logic             reset;
   logic             rx;
   logic [DIV_W-1:0] baud_count;
   logic             eight, pen, ohel, clr_rdy;
   logic [7:0]       rx_data;
   logic             rx_rdy, perr, ferr, ovf;

   typedef struct {
      logic [7:0] data;
      logic       perr;
      logic       ferr;
      logic       ovf;
      int         due;
   } exp_t;

   exp_t q[$];
   exp_t mon;
   int   cyc    = 0;
   int   checks = 0;
   int   errors = 0;

   uart_rx_engine #(
      .DIV_W (DIV_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .baud_count (baud_count),
      .eight      (eight),
      .pen        (pen),
      .ohel       (ohel),
      .clr_rdy    (clr_rdy),
      .rx_data    (rx_data),
      .rx_rdy     (rx_rdy),
      .perr       (perr),
      .ferr       (ferr),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=0x%02h required=0x%02h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Outputs are due one clock after the stop-bit sample.
   always @(negedge clk) begin
      if (q.size() > 0 && cyc == q[0].due) begin
         mon = q.pop_front();
         chk($sformatf("rx_rdy[%02h]", mon.data), {7'd0, rx_rdy}, 8'd1);
         chk($sformatf("rx_data[%02h]", mon.data), rx_data, mon.data);
         chk($sformatf("perr[%02h]", mon.data), {7'd0, perr}, {7'd0, mon.perr});
         chk($sformatf("ferr[%02h]", mon.data), {7'd0, ferr}, {7'd0, mon.ferr});
         chk($sformatf("ovf[%02h]", mon.data), {7'd0, ovf}, {7'd0, mon.ovf});
      end
   end

   task automatic send_frame(input logic [7:0] d, input int b, input bit e8, input bit p_en,
                             input bit odd, input bit par_bit, input bit stop,
                             input bit clr_done, input bit scramble,
                             input logic [7:0] x_data, input bit x_perr, input bit x_ferr,
                             input bit x_ovf);
      int         n;
      exp_t       ex;
      logic [9:0] bits;
      n = 8 + int'(e8) + int'(p_en);
      bits = 10'h3FF;
      for (int i = 0; i < 7 + int'(e8); i++) bits[i] = d[i];
      if (p_en) bits[7 + int'(e8)] = par_bit;
      bits[n - 1] = stop;
      @(negedge clk);
      baud_count = DIV_W'(b);
      eight      = e8;
      pen        = p_en;
      ohel       = odd;
      rx         = 1'b0;
      ex.data    = x_data;
      ex.perr    = x_perr;
      ex.ferr    = x_ferr;
      ex.ovf     = x_ovf;
      ex.due     = cyc + 5 + b / 2 + b * n;
      q.push_back(ex);
      repeat (b) @(negedge clk);
      if (scramble) begin
         baud_count = 19'd7;
         eight      = ~e8;
         pen        = ~p_en;
         ohel       = ~odd;
      end
      for (int i = 0; i < n; i++) begin
         rx = bits[i];
         for (int k = 0; k < b; k++) begin
            clr_rdy = clr_done && (cyc == ex.due - 1);
            @(negedge clk);
         end
      end
      rx      = 1'b1;
      clr_rdy = 1'b0;
   endtask

   task automatic clr_pulse();
      @(negedge clk);
      clr_rdy = 1'b1;
      @(negedge clk);
      clr_rdy = 1'b0;
      chk("clr_rx_rdy", {7'd0, rx_rdy}, 8'd0);
      chk("clr_perr", {7'd0, perr}, 8'd0);
      chk("clr_ferr", {7'd0, ferr}, 8'd0);
      chk("clr_ovf", {7'd0, ovf}, 8'd0);
   endtask

   initial begin
      reset      = 1'b0;
      rx         = 1'b1;
      baud_count = 19'd16;
      eight      = 1'b1;
      pen        = 1'b0;
      ohel       = 1'b0;
      clr_rdy    = 1'b0;
      repeat (3) @(negedge clk);
      chk("reset_rx_data", rx_data, 8'h00);
      chk("reset_rx_rdy", {7'd0, rx_rdy}, 8'd0);
      chk("reset_perr", {7'd0, perr}, 8'd0);
      chk("reset_ferr", {7'd0, ferr}, 8'd0);
      chk("reset_ovf", {7'd0, ovf}, 8'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      // data, b, eight, pen, odd, parbit, stop, clr_done, scramble, expected
      send_frame(8'hA5, 16, 1, 0, 0, 0, 1, 0, 0, 8'hA5, 0, 0, 0);  // 8N1
      clr_pulse();
      send_frame(8'h41, 16, 0, 1, 0, 0, 1, 0, 0, 8'h41, 0, 0, 0);  // 7E1 good parity
      clr_pulse();
      send_frame(8'h41, 16, 0, 1, 1, 0, 1, 0, 0, 8'h41, 1, 0, 0);  // 7O1 bad parity
      clr_pulse();
      send_frame(8'hC1, 12, 0, 0, 0, 0, 1, 0, 0, 8'h41, 0, 0, 0);  // 7N1, bit 7 forced 0
      clr_pulse();
      send_frame(8'h80, 10, 1, 1, 1, 0, 1, 0, 1, 8'h80, 0, 0, 0);  // 8O1, config changed mid-frame
      clr_pulse();

      // Short low glitch must be rejected at the half-bit check.
      @(negedge clk);
      baud_count = 19'd16;
      rx         = 1'b0;
      repeat (5) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("glitch_rx_rdy", {7'd0, rx_rdy}, 8'd0);
      chk("glitch_ferr", {7'd0, ferr}, 8'd0);

      send_frame(8'h3C, 16, 1, 0, 0, 0, 0, 0, 0, 8'h3C, 0, 1, 0);  // stop = 0
      send_frame(8'h5A, 16, 1, 0, 0, 0, 1, 0, 0, 8'h5A, 0, 0, 1);  // overrun
      clr_pulse();
      send_frame(8'h12, 16, 1, 0, 0, 0, 1, 0, 0, 8'h12, 0, 0, 0);
      send_frame(8'h55, 16, 1, 0, 0, 0, 1, 1, 0, 8'h55, 0, 0, 0);  // clr_rdy during DONE
      clr_pulse();

      // Break: line held low through a whole frame and beyond.
      @(negedge clk);
      baud_count = 19'd16;
      eight      = 1'b1;
      pen        = 1'b0;
      rx         = 1'b0;
      mon.data   = 8'h00;
      mon.perr   = 1'b0;
      mon.ferr   = 1'b1;
      mon.ovf    = 1'b0;
      mon.due    = cyc + 5 + 8 + 16 * 10;
      q.push_back(mon);
      repeat (16 * 12) @(negedge clk);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      chk("break_rx_rdy_held", {7'd0, rx_rdy}, 8'd1);
      chk("break_ferr_held", {7'd0, ferr}, 8'd1);

      // Reset after start plus four data bits.
      @(negedge clk);
      rx = 1'b0;
      repeat (16) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         rx = i[0];
         repeat (16) @(negedge clk);
      end
      reset = 1'b0;
      #1;
      chk("midreset_rx_data", rx_data, 8'h00);
      chk("midreset_rx_rdy", {7'd0, rx_rdy}, 8'd0);
      chk("midreset_perr", {7'd0, perr}, 8'd0);
      chk("midreset_ferr", {7'd0, ferr}, 8'd0);
      chk("midreset_ovf", {7'd0, ovf}, 8'd0);
      rx = 1'b1;
      repeat (5) @(negedge clk);
      reset = 1'b1;
      repeat (5) @(negedge clk);
      send_frame(8'hFF, 16, 1, 1, 0, 0, 1, 0, 0, 8'hFF, 0, 0, 0);  // 8E1 after reset

      repeat (20) @(negedge clk);
      chk("queue_drained", 8'(q.size()), 8'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
